// File: rtl/fastcmd_delay_scheduler_if.sv
// Config, command and delayed-output bundle between a fast-command source and the delay scheduler.
// The slave modport is the scheduler side; the master modport is the command source / controller.
interface fastcmd_delay_scheduler_if #(
  parameter int CNT_W  = 9,
  parameter int DEPTH  = 8,
  parameter int CODE_W = 4
);
  logic [CNT_W-1:0]       cfgDelay;
  logic                   cfgLoad;
  logic                   cfgDone;
  logic [CNT_W-1:0]       activeDelay;
  logic                   cmdValid;
  logic [CODE_W-1:0]      cmdCode;
  logic                   outValid;
  logic [CODE_W-1:0]      outCode;
  logic [$clog2(DEPTH):0] pending;
  logic                   busy;
  logic                   overflow;
  logic                   cfgDrop;
  logic [7:0]             dropCount;

  modport master (
    output cfgDelay, cfgLoad, cmdValid, cmdCode,
    input  cfgDone, activeDelay, outValid, outCode, pending, busy, overflow, cfgDrop, dropCount
  );

  modport slave (
    input  cfgDelay, cfgLoad, cmdValid, cmdCode,
    output cfgDone, activeDelay, outValid, outCode, pending, busy, overflow, cfgDrop, dropCount
  );
endinterface

// File: rtl/fastcmd_delay_scheduler.sv
// Programmable-latency fast-command scheduler: in-flight {code, due-time} entries in a FIFO against a free-running timestamp.
// Define FC_DELAY_STATS_EN to build the saturating dropped-command counter; otherwise dropCount reads 0.
module fastcmd_delay_scheduler #(
  parameter int CNT_W     = 9,
  parameter int DEPTH     = 8,
  parameter int CODE_W    = 4,
  parameter int DEF_DELAY = 7
) (
  input logic clk,
  input logic rst,
  fastcmd_delay_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W:0] cntT;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

  stateT             state;
  logic [CNT_W-1:0]  ts;
  logic [CNT_W-1:0]  activeDelayReg;
  logic [CNT_W-1:0]  shadowDelay;
  logic [CODE_W-1:0] codeMem [DEPTH];
  logic [CNT_W-1:0]  dueMem  [DEPTH];
  cntT               wrPtr;
  cntT               rdPtr;
  cntT               pendingReg;
  cntT               pendingNext;
  logic              outValidReg;
  logic [CODE_W-1:0] outCodeReg;
  logic              cfgDoneReg;
  logic              busyReg;
  logic              overflowReg;
  logic              cfgDropReg;

  logic              fifoPop;
  logic              canAccept;
  logic              cmdAccept;
  logic              ovfDrop;
  logic              drainDrop;
  logic              bypass;
  logic              fifoPush;
  logic [CNT_W-1:0]  reqDelay;

  // pending counts the entry currently on the output too, so a full scheduler
  // can still take a command in the cycle its oldest entry is being emitted.
  always_comb begin
    fifoPop     = (wrPtr != rdPtr) && (dueMem[rdPtr[PTR_W-1:0]] == ts + CNT_W'(1));
    canAccept   = (pendingReg != cntT'(DEPTH)) || outValidReg;
    cmdAccept   = bus.cmdValid && (state != DRAIN) && canAccept;
    ovfDrop     = bus.cmdValid && (state != DRAIN) && !canAccept;
    drainDrop   = bus.cmdValid && (state == DRAIN);
    bypass      = cmdAccept && (activeDelayReg == CNT_W'(1));
    fifoPush    = cmdAccept && !bypass;
    pendingNext = pendingReg + cntT'(cmdAccept) - cntT'(outValidReg);
    reqDelay    = (bus.cfgDelay == '0) ? CNT_W'(1) : bus.cfgDelay;
  end

  always_ff @(posedge clk) begin
    if (fifoPush) begin
      codeMem[wrPtr[PTR_W-1:0]] <= bus.cmdCode;
      dueMem[wrPtr[PTR_W-1:0]]  <= ts + activeDelayReg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts             <= '0;
      wrPtr          <= '0;
      rdPtr          <= '0;
      pendingReg     <= '0;
      outValidReg    <= 1'b0;
      outCodeReg     <= '0;
      activeDelayReg <= CNT_W'(DEF_DELAY);
      shadowDelay    <= CNT_W'(DEF_DELAY);
      state          <= IDLE;
      cfgDoneReg     <= 1'b0;
      busyReg        <= 1'b0;
      overflowReg    <= 1'b0;
      cfgDropReg     <= 1'b0;
    end else begin
      ts         <= ts + CNT_W'(1);
      pendingReg <= pendingNext;
      cfgDoneReg <= 1'b0;
      if (fifoPush) wrPtr <= wrPtr + cntT'(1);
      if (fifoPop)  rdPtr <= rdPtr + cntT'(1);
      // A delay of 1 never leaves anything in the FIFO, so pop and bypass are exclusive.
      outValidReg <= fifoPop || bypass;
      outCodeReg  <= fifoPop ? codeMem[rdPtr[PTR_W-1:0]] : (bypass ? bus.cmdCode : '0);
      if (ovfDrop)   overflowReg <= 1'b1;
      if (drainDrop) cfgDropReg  <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.cfgLoad && cmdAccept) begin
            shadowDelay <= reqDelay;
            busyReg     <= 1'b1;
            state       <= DRAIN;
          end else if (bus.cfgLoad) begin
            activeDelayReg <= reqDelay;
            cfgDoneReg     <= 1'b1;
          end else if (cmdAccept) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.cfgLoad) begin
            shadowDelay <= reqDelay;
            busyReg     <= 1'b1;
            state       <= DRAIN;
          end else if (pendingNext == '0) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.cfgLoad) shadowDelay <= reqDelay;
          // A request landing in the completing cycle is the newest, so it wins.
          if (pendingNext == '0) begin
            activeDelayReg <= bus.cfgLoad ? reqDelay : shadowDelay;
            cfgDoneReg     <= 1'b1;
            busyReg        <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FC_DELAY_STATS_EN
  logic [7:0] dropCountReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dropCountReg <= '0;
    end else if ((ovfDrop || drainDrop) && (dropCountReg != 8'hFF)) begin
      dropCountReg <= dropCountReg + 8'd1;
    end
  end

  assign bus.dropCount = dropCountReg;
`else
  assign bus.dropCount = 8'd0;
`endif

  assign bus.outValid    = outValidReg;
  assign bus.outCode     = outCodeReg;
  assign bus.cfgDone     = cfgDoneReg;
  assign bus.activeDelay = activeDelayReg;
  assign bus.pending     = pendingReg;
  assign bus.busy        = busyReg;
  assign bus.overflow    = overflowReg;
  assign bus.cfgDrop     = cfgDropReg;
endmodule
